// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the parity
// function used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } rx_state_e;

    // Expected parity bit: even_odd=1 selects even parity, 0 selects odd.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                         input logic                 even_odd);
        return even_odd ? (^data) : ~(^data);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter for the UART receiver. Counts 0..CLKS_PER_BIT-1 and wraps;
// mid_tick_o marks the half-bit point (plus MID_OFFSET), bit_tick_o the last
// count of each bit period.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned MID_OFFSET   = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic mid_tick_o,
    output logic bit_tick_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] MidPt  = CntW'(CLKS_PER_BIT / 2 + MID_OFFSET);
    localparam logic [CntW-1:0] LastPt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, otherwise wrap at the end of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LastPt) ? '0 : cnt_q + CntW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mid_tick_o = (cnt_q == MidPt);
    assign bit_tick_o = (cnt_q == LastPt);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start, 8 data bits LSB first, parity, stop.
// Optional macro UART_RX_MAJORITY_EN: each bit decision (including the start
// confirmation) is a 2-of-3 vote around the midpoint, one cycle later.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 serial_in,
    input  logic                 even_odd,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [BIT_CNT_W-1:0] LastBit = BIT_CNT_W'(DATA_BITS - 1);

    rx_state_e              state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   perr_q, perr_d;
    logic                   perr_out_q, perr_out_d;
    logic                   ferr_q, ferr_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   sync1_q, rx_s_q;
    logic                   samp;
    logic                   baud_clear;
    logic                   mid_tick, bit_tick;

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            rx_s_q  <= sync1_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned MidOffset = 1;
    logic hist0_q, hist1_q;

    // History of the two previous synchronized samples for the vote.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            hist0_q <= 1'b1;
            hist1_q <= 1'b1;
        end else begin
            hist0_q <= rx_s_q;
            hist1_q <= hist0_q;
        end
    end

    // Ticks land one cycle after the midpoint, so the window is mid-1..mid+1.
    assign samp = (rx_s_q & hist0_q) | (rx_s_q & hist1_q) | (hist0_q & hist1_q);
`else
    localparam int unsigned MidOffset = 0;
    assign samp = rx_s_q;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .MID_OFFSET   (MidOffset)
    ) u_baud_cnt (
        .clk_i      (sys_clk),
        .rst_ni     (rst_n),
        .clear_i    (baud_clear),
        .enable_i   (1'b1),
        .mid_tick_o (mid_tick),
        .bit_tick_o (bit_tick)
    );

    // Frame FSM next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        perr_d     = perr_q;
        perr_out_d = perr_out_q;
        ferr_d     = ferr_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        baud_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_clear = 1'b1;
                busy_d     = 1'b0;
                if (!rx_s_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (mid_tick) begin
                    if (!samp) begin
                        // Realign the counter to the start-bit centre.
                        state_d    = StData;
                        busy_d     = 1'b1;
                        baud_clear = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (bit_tick) begin
                    shift_d = {samp, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        state_d   = StParity;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            StParity: begin
                if (bit_tick) begin
                    perr_d  = samp ^ calc_parity(shift_q, even_odd);
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_tick) begin
                    data_d     = shift_q;
                    valid_d    = 1'b1;
                    perr_out_d = perr_q;
                    ferr_d     = !samp;
                    if (samp) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                // Hold off on a break so it is not decoded as repeated 0x00.
                if (rx_s_q) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_data_out = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = perr_out_q;
    assign frame_err   = ferr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver with a scoreboard of expected frames.
module tb_uart_receiver;

    localparam int unsigned CPB = 16;

    logic       sys_clk   = 1'b0;
    logic       rst_n     = 1'b0;
    logic       serial_in = 1'b1;
    logic       even_odd  = 1'b1;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       busy;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned valid_cyc[$];
    int unsigned n_checks  = 0;
    int unsigned n_pass    = 0;
    int unsigned cyc       = 0;
    int unsigned valid_cnt = 0;

    uart_receiver #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .serial_in   (serial_in),
        .even_odd    (even_odd),
        .rx_data_out (rx_data_out),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: every rx_valid pops one expected frame.
    always @(negedge sys_clk) begin
        cyc++;
        if (rst_n && rx_valid) begin
            valid_cnt++;
            valid_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("data", {24'd0, rx_data_out}, {24'd0, mon_e.data});
                check_eq("parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
                check_eq("frame_err", {31'd0, frame_err}, {31'd0, mon_e.ferr});
                check_eq("busy_at_valid", {31'd0, busy}, {31'd0, mon_e.busy});
            end
        end
    end

    task automatic hold(input logic v, input int unsigned n);
        serial_in = v;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                              input logic eo, input logic exp_busy);
        exp_t x;
        even_odd = eo;
        x.data   = d;
        x.perr   = pbit ^ (eo ? (^d) : ~(^d));
        x.ferr   = !sbit;
        x.busy   = exp_busy;
        exp_q.push_back(x);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(pbit, CPB);
        hold(sbit, CPB);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 * CPB; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge sys_clk);
        end
        check_eq(tag, exp_q.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data"}, {24'd0, rx_data_out}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
        check_eq({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
        check_eq({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    int unsigned v0;
    int unsigned n0;
    int unsigned diff;

    initial begin
        // Reset state.
        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        hold(1'b1, 2 * CPB);

        // 1: clean frame 0xCC, even parity.
        send_frame(8'hCC, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * CPB);
        wait_drain("t1_drain");
        check_eq("t1_busy_after", {31'd0, busy}, 32'd0);

        // 2: bad parity under even, then good parity under odd.
        send_frame(8'hCC, 1'b1, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * CPB);
        send_frame(8'hCC, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 2 * CPB);
        wait_drain("t2_drain");

        // 3: framing error followed by a break.
        v0 = valid_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
        hold(1'b0, 3 * CPB);
        check_eq("t3_busy_in_break", {31'd0, busy}, 32'd1);
        hold(1'b1, 2 * CPB);
        check_eq("t3_busy_after", {31'd0, busy}, 32'd0);
        check_eq("t3_single_valid", valid_cnt, v0 + 1);
        wait_drain("t3_drain");

        // 4: short glitch is a false start.
        v0 = valid_cnt;
        hold(1'b0, CPB / 4);
        hold(1'b1, CPB / 2);
        check_eq("t4_busy_mid", {31'd0, busy}, 32'd0);
        hold(1'b1, 2 * CPB);
        check_eq("t4_busy_end", {31'd0, busy}, 32'd0);
        check_eq("t4_no_valid", valid_cnt, v0);

        // 5: back-to-back frames.
        n0 = valid_cyc.size();
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * CPB);
        wait_drain("t5_drain");
        diff = 0;
        if (valid_cyc.size() >= n0 + 2) diff = valid_cyc[n0 + 1] - valid_cyc[n0];
        check_eq("t5_spacing", {31'd0, (diff >= 11 * CPB - 1) && (diff <= 11 * CPB + 1)}, 32'd1);

        // 6: reset during data bit 4 of 0xF0 aborts the frame.
        v0 = valid_cnt;
        hold(1'b0, CPB);
        hold(1'b0, 4 * CPB);
        hold(1'b1, CPB / 2);
        rst_n = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        check_all_zero("t6_reset");
        hold(1'b1, 12 * CPB);
        check_eq("t6_no_valid", valid_cnt, v0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 2 * CPB);
        wait_drain("t6_drain");

`ifdef UART_RX_MAJORITY_EN
        // Single-cycle inversion at a data-bit midpoint is voted out.
        begin
            exp_t x;
            logic [7:0] d;
            d        = 8'h96;
            even_odd = 1'b1;
            x.data   = d;
            x.perr   = 1'b0;
            x.ferr   = 1'b0;
            x.busy   = 1'b0;
            exp_q.push_back(x);
            hold(1'b0, CPB);
            for (int i = 0; i < 8; i++) begin
                if (i == 2) begin
                    hold(d[i], CPB / 2 + 2);
                    hold(~d[i], 1);
                    hold(d[i], CPB / 2 - 3);
                end else begin
                    hold(d[i], CPB);
                end
            end
            hold(^d, CPB);
            hold(1'b1, CPB);
            hold(1'b1, 2 * CPB);
            wait_drain("maj_drain");
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive path; the counterpart of the team's UART transmitter on the same link.
- Recovers 8N-with-parity frames from serial_in: start bit, 8 data bits LSB first, 1 parity bit, 1 stop bit.
- Presents each byte on rx_data_out with a one-cycle rx_valid strobe plus parity/framing error flags.
- Sits between the board RX pin and the host-side command logic.

Parameters:
CLKS_PER_BIT, 5208, sys_clk cycles per bit period (50 MHz / 9600 baud); minimum 8.
DATA_BITS, 8, data bits per frame; fixed, taken from the package constant.

Ports:
sys_clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on sys_clk rising edge
serial_in  input  1  asynchronous serial line, idle high
even_odd  input  1  parity select: 1 = even parity, 0 = odd parity; sampled at the parity-bit midpoint
rx_data_out  output  8  last received byte; held until the next rx_valid
rx_valid  output  1  one-cycle pulse when a frame completes
parity_err  output  1  parity result of the last frame; updated with rx_valid
frame_err  output  1  stop bit sampled low in the last frame; updated with rx_valid
busy  output  1  high from confirmed start bit until return to IDLE

Behaviour:
- Reset (rst_n low at a clock edge) forces:
  - rx_data_out=0, rx_valid=0, parity_err=0, frame_err=0, busy=0.
  - State IDLE, bit counter and baud counter 0, synchronizer flops to 1.
- Reset mid-frame aborts the frame: no rx_valid, no flag update.
- serial_in passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Half-bit point = CLKS_PER_BIT/2, integer division.
- IDLE:
  - rx_s low -> START; clear baud counter.
  - busy=0.
- START:
  - At half-bit point, rx_s low -> DATA, busy=1, baud counter cleared. Later samples then fall at bit midpoints.
  - At half-bit point, rx_s high -> false start; return to IDLE with no outputs changed.
- DATA:
  - At each full bit period, shift rx_s into the MSB of the shift register (LSB-first reception).
  - After the 8th sample -> PARITY.
- PARITY:
  - At full bit period, compute expected parity: even_odd=1 -> XOR of data bits; even_odd=0 -> its inverse.
  - Register mismatch internally; -> STOP.
- STOP, at full bit period:
  - Load rx_data_out from the shift register.
  - Pulse rx_valid for exactly one cycle.
  - Drive parity_err from the registered mismatch; set frame_err = !rx_s.
  - rx_s high -> IDLE. busy drops in the same cycle rx_valid rises.
  - rx_s low (frame error or break) -> WAIT_HIGH.
- WAIT_HIGH: busy=1; stay until rx_s high, then -> IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.
- The byte is delivered on rx_valid even when it has an error.
- rx_valid rises no later than CLKS_PER_BIT/2 + 3 cycles after the stop-bit centre on the raw pin.
- Back-to-back frames: IDLE is re-entered at the stop-bit midpoint, so a start edge immediately after the stop bit is caught. No gap is required.
- There is no consumer handshake; the host must read within one frame time. A new byte overwrites rx_data_out.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined:
  - Each data, parity and stop bit is the 2-of-3 majority of rx_s taken at midpoint-1, midpoint and midpoint+1 cycles.
  - The start-bit confirmation uses the same vote.
  - Decision timing moves 1 cycle later; rx_valid latency grows by 1 cycle.
- Undefined: a single midpoint sample is used, with no extra flops.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - DATA_BITS=8;
  - a parity function calc_parity(data, even_odd), shared with the transmitter so both ends agree.
- Sub-module uart_baud_cnt: clear/enable inputs, mid_tick and bit_tick outputs, parameterised by CLKS_PER_BIT.
- The synchronizer stays inline.

Test Plan:
1. Byte 0xCC, even_odd=1, parity bit 0, stop 1, CLKS_PER_BIT=16 -> one rx_valid pulse, rx_data_out=0xCC, parity_err=0, frame_err=0, busy low after the pulse.
2. Byte 0xCC with parity bit forced to 1, even_odd=1 -> rx_data_out=0xCC, parity_err=1. Repeat with even_odd=0, parity bit 1 -> parity_err=0.
3. Byte 0x5A with stop bit 0, line held low 3 bit times -> rx_valid with frame_err=1; busy stays 1 until the line goes high; no second rx_valid.
4. Low glitch of CLKS_PER_BIT/4 cycles on an idle line -> no rx_valid, busy stays 0, state returns to IDLE.
5. Frames 0x55 then 0xA3 back-to-back (next start immediately after stop) -> two rx_valid pulses exactly 11*CLKS_PER_BIT ±1 apart, data 0x55 then 0xA3, no errors.
6. rst_n low for 1 cycle during data bit 4 of 0xF0 -> all outputs 0, no rx_valid; a following clean frame 0x3C received correctly. With UART_RX_MAJORITY_EN, a 1-cycle inversion at the midpoint of a data bit does not corrupt the byte.
